// File: rtl/ngv_lcd_bus.sv
// rtl/ngv_lcd_bus.sv - 8080-style write-only LCD bus driver with input FIFO
//
// Accepts {rs, data} words over a valid/ready handshake, buffers them in a
// small FIFO and replays each one on the parallel panel bus as a
// chip-select / write-strobe cycle with programmable setup, low and high
// times. Consecutive words are sent as a burst without releasing scs.
//
// Optional feature macro: NGV_LCD_HWRST_EN
//   defined     - after reset the FSM drives srst low for RST_LOW cycles,
//                 then waits RST_WAIT cycles before the first transfer.
//   not defined - the FSM starts in IDLE and srst is held at 1.
//
// Ports:
//   pclk      in   clock, rising edge
//   prst      in   asynchronous active-low reset
//   in_valid  in   word offered
//   in_ready  out  registered, equals !full
//   in_rs     in   0 = command, 1 = data
//   in_data   in   24-bit bus word
//   bl_on     in   backlight request
//   busy      out  FSM active or FIFO holding words
//   sblk      out  backlight, registered copy of bl_on
//   scs       out  chip select, active low
//   srs       out  register select
//   swr       out  write strobe, active low
//   srd       out  read strobe, constant 1
//   srst      out  panel reset, active low
//   sdata     out  24-bit bus data
module ngv_lcd_bus #(
    parameter int CS_SETUP   = 1,
    parameter int WR_LOW     = 2,
    parameter int WR_HIGH    = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int RST_LOW    = 16,
    parameter int RST_WAIT   = 64
) (
    input  logic        pclk,
    input  logic        prst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_rs,
    input  logic [23:0] in_data,
    input  logic        bl_on,
    output logic        busy,
    output logic        sblk,
    output logic        scs,
    output logic        srs,
    output logic        swr,
    output logic        srd,
    output logic        srst,
    output logic [23:0] sdata
);

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int MAX_A   = (CS_SETUP > WR_LOW) ? CS_SETUP : WR_LOW;
    localparam int MAX_B   = (WR_HIGH > RST_LOW) ? WR_HIGH : RST_LOW;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CNT = (MAX_C > RST_WAIT) ? MAX_C : RST_WAIT;
    localparam int CW      = $clog2(MAX_CNT + 1);

    // Counter load values: a state lasting N cycles loads N-1 on entry.
    localparam logic [CW-1:0] LD_SETUP = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] LD_WR_LO = CW'(WR_LOW - 1);
    localparam logic [CW-1:0] LD_WR_HI = CW'(WR_HIGH - 1);
`ifdef NGV_LCD_HWRST_EN
    localparam logic [CW-1:0] LD_RST_LO = CW'(RST_LOW - 1);
    localparam logic [CW-1:0] LD_RST_WT = CW'(RST_WAIT - 1);
`endif

    typedef enum logic [2:0] {
        ST_RST_LO,
        ST_RST_WT,
        ST_IDLE,
        ST_SETUP,
        ST_WR_LO,
        ST_WR_HI
    } state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           scs_q;
    logic           swr_q;
    logic           srs_q;
    logic           srd_q;
    logic           srst_q;
    logic [23:0]    sdata_q;
    logic           sblk_q;
    logic           in_ready_q;
    logic           busy_q;

    // FIFO storage and pointers (one extra bit distinguishes full from empty)
    logic [24:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]    wr_ptr_q;
    logic [AW:0]    rd_ptr_q;
    logic [AW:0]    wr_ptr_d;
    logic [AW:0]    rd_ptr_d;
    logic           full_d;
    logic           empty;
    logic           nempty_q;
    logic           can_pop;
    logic           push;
    logic           pop;
    logic [24:0]    head;

    assign push  = in_valid && in_ready_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    // The pop decision uses a one-cycle-delayed non-empty flag, giving the
    // two-edge push-to-scs latency; gating with !empty keeps a stale flag
    // from ever popping an empty FIFO.
    assign can_pop = nempty_q && !empty;
    assign head    = mem_q[rd_ptr_q[AW-1:0]];
    assign pop     = can_pop &&
                     ((state_q == ST_IDLE) || ((state_q == ST_WR_HI) && (cnt_q == '0)));

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        full_d   = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                   (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge pclk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {in_rs, in_data};
        end
    end

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            nempty_q   <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            sblk_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            nempty_q   <= !empty;
            in_ready_q <= !full_d;
            busy_q     <= (state_q != ST_IDLE) || !empty || push;
            sblk_q     <= bl_on;
        end
    end

    always_ff @(posedge pclk or negedge prst) begin
        if (!prst) begin
`ifdef NGV_LCD_HWRST_EN
            state_q <= ST_RST_LO;
            cnt_q   <= LD_RST_LO;
            srst_q  <= 1'b0;
`else
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            srst_q  <= 1'b1;
`endif
            scs_q   <= 1'b1;
            swr_q   <= 1'b1;
            srs_q   <= 1'b0;
            srd_q   <= 1'b1;
            sdata_q <= '0;
        end else begin
            case (state_q)
`ifdef NGV_LCD_HWRST_EN
                ST_RST_LO: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_RST_WT;
                        cnt_q   <= LD_RST_WT;
                        srst_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_RST_WT: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
`endif
                ST_IDLE: begin
                    if (pop) begin
                        state_q <= ST_SETUP;
                        cnt_q   <= LD_SETUP;
                        scs_q   <= 1'b0;
                        srs_q   <= head[24];
                        sdata_q <= head[23:0];
                    end
                end
                ST_SETUP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_WR_LO;
                        cnt_q   <= LD_WR_LO;
                        swr_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_WR_LO: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_WR_HI;
                        cnt_q   <= LD_WR_HI;
                        swr_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_WR_HI: begin
                    if (cnt_q == '0) begin
                        if (pop) begin
                            // Burst: next word goes out without releasing scs.
                            state_q <= ST_SETUP;
                            cnt_q   <= LD_SETUP;
                            srs_q   <= head[24];
                            sdata_q <= head[23:0];
                        end else begin
                            state_q <= ST_IDLE;
                            scs_q   <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    scs_q   <= 1'b1;
                    swr_q   <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign sblk     = sblk_q;
    assign scs      = scs_q;
    assign srs      = srs_q;
    assign swr      = swr_q;
    assign srd      = srd_q;
    assign srst     = srst_q;
    assign sdata    = sdata_q;

endmodule

// File: doc/ngv_lcd_bus.md
# ngv_lcd_bus

Upstream driver for the NGV LCD path. It accepts command/data words over a valid/ready handshake and buffers them in a small FIFO. It generates the 8080-style write-only parallel bus (`sblk`, `scs`, `srs`, `swr`, `srd`, `srst`, `sdata`) with programmable strobe timing. Its outputs connect directly to the `s*` inputs of the LCD output stage in `ngv_conv`, and it optionally runs the panel hardware-reset sequence after power-up.

## Interface
- `CS_SETUP`, 1: cycles `scs` low / data valid before `swr` falls (min 1).
- `WR_LOW`, 2: cycles `swr` held low (min 1).
- `WR_HIGH`, 2: cycles `swr` held high after the rising edge, data held (min 1).
- `FIFO_DEPTH`, 4: entries, power of two, ≥2.
- `RST_LOW`, 16: cycles `srst` held low (hardware-reset build only).
- `RST_WAIT`, 64: cycles after `srst` rises before the first transfer (hardware-reset build only).

Ports:
- `pclk`  in  1  Single clock, rising edge.
- `prst`  in  1  Asynchronous, active-low reset.
- `in_valid`  in  1  Word offered.
- `in_ready`  out  1  Registered; equals !full.
- `in_rs`  in  1  0 = command, 1 = data.
- `in_data`  in  24  Bus word.
- `bl_on`  in  1  Backlight request.
- `busy`  out  1  Asserted when FSM ≠ IDLE or FIFO non-empty.
- `sblk`  out  1  Backlight, registered copy of `bl_on`.
- `scs`  out  1  Chip select, active low.
- `srs`  out  1  Register select.
- `swr`  out  1  Write strobe, active low.
- `srd`  out  1  Read strobe; constant 1.
- `srst`  out  1  Panel reset, active low.
- `sdata`  out  24  Bus data.

## Operation
- All outputs are registered. Reset values: `scs`=1, `swr`=1, `srd`=1, `srs`=0, `sdata`=0, `sblk`=0, `in_ready`=0, `busy`=1. `srst` resets to 0 with `NGV_LCD_HWRST_EN` defined, and to 1 without it. FIFO is emptied on reset.
- FIFO:
  - 25-bit entries {rs, data}.
  - Push on `in_valid && in_ready`.
  - `in_ready` depends only on full, so no push occurs while full, even in a pop cycle.
  - Pointers are one bit wider than the address; wrap-around is modulo 2·`FIFO_DEPTH`.
- FSM states: RST_LO, RST_WT, IDLE, SETUP, WR_LO, WR_HI. A down-counter, sized to the largest parameter, is loaded on each state entry.
  - RST_LO: `srst`=0 for `RST_LOW` cycles → RST_WT (`srst`=1).
  - RST_WT: hold for `RST_WAIT` cycles → IDLE.
  - IDLE: if FIFO non-empty, pop; load `srs`/`sdata`; drive `scs`=0 → SETUP.
  - SETUP (`CS_SETUP` cycles) → WR_LO.
  - WR_LO: `swr`=0 for `WR_LOW` cycles → WR_HI (`swr`=1).
  - WR_HI (`WR_HIGH` cycles), then:
    - If FIFO non-empty: pop, load next `srs`/`sdata`, keep `scs`=0 → SETUP (burst).
    - Otherwise: `scs`=1 → IDLE.
- `sdata`/`srs` change only on SETUP entry and are stable from then until the next load or IDLE.
- Pushes are accepted during RST_LO/RST_WT; words wait in the FIFO.
- `sblk` follows `bl_on` with 1-cycle latency in all states, including reset sequencing.

## Timing
- Push at edge t0 into an empty FIFO with the FSM in IDLE:
  - `scs`↓ and `sdata` valid after edge t0+2.
  - `swr`↓ after t0+2+`CS_SETUP`.
  - `swr`↑ after a further `WR_LOW` cycles.
  - `scs`↑ after a further `WR_HIGH` cycles if no word is pending.
- With defaults: `scs` low 5 cycles per word. A burst of N words gives `scs` low for 5N contiguous cycles, with strobes spaced 5 cycles apart.
- `in_ready` rises 1 cycle after `prst` deasserts.
- Asynchronous `prst` assertion mid-transfer forces reset values immediately, with no clock required. The in-flight word is lost and not replayed.

## Configuration
- `NGV_LCD_HWRST_EN` defined: the FSM leaves reset in RST_LO and performs the `srst` pulse and wait before the first transfer.
- Not defined: the FSM leaves reset in IDLE, `srst` is constant 1, and `RST_LOW`/`RST_WAIT` are unused. RST_LO/RST_WT logic is not compiled.

## Test plan
- Macro on, defaults: release `prst` while pushing one word immediately → `srst` low exactly 16 cycles, then high; `scs` stays high until 64 cycles after `srst`↑, then the word transfers.
- Macro off: push {rs=0, 0x00002C} at t0 → `scs`↓ after t0+2, `swr` low cycles 3–4, `srs`=0, `sdata`=0x00002C for all 5 `scs`-low cycles; `srst`=1 throughout.
- Burst: push 4 data words 0x111111..0x444444 back-to-back → `scs` low 20 contiguous cycles, 4 `swr` pulses in order, `srs`=1.
- Overflow: hold `in_valid` for 8 distinct words with the FSM busy → `in_ready` drops at full; every word appears exactly once, in order.
- Async reset in WR_LO → `swr`/`scs` return to 1 and `sdata` to 0 before the next clock edge; `busy`=1 during reset, then FSM and FIFO are empty afterwards (`busy`=0, macro off).
- Toggle `bl_on` 0→1→0 → `sblk` mirrors it delayed 1 cycle, including during a burst.
